div_acc: RTL and testbench

//  Iterative divider accelerator, directly downstream of the core controller.
//  It consumes the controller's divide-loop detection (StartDiv102, Divident, Divisor).
//  It computes the quotient/remainder the software loop would leave in M[1]/M[2]/D,

---
 rtl/div_acc.sv | 176 +++++++++++++++++
 tb/tb_div_acc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_acc.sv
// Iterative restoring divider that replaces the software divide loop and injects
// a four-pair A/C instruction sequence leaving M[1]=Q, M[2]=R and D=R.
module div_acc #(
  parameter int DW        = 16,
  parameter int OPW       = 15,
  parameter int STEP_BITS = 1
) (
  input  logic          Clk,
  input  logic          Reset_N,
  input  logic          StartDiv102,
  input  logic [DW-1:0] Divident,
  input  logic [DW-1:0] Divisor,
  input  logic          RstCtrlJmp103,
  output logic          SelAccInst101,
  output logic [DW-1:0] Inst0FromAcc101,
  output logic [DW-1:0] Inst1FromAcc101,
  output logic          AccStall,
  output logic          DivByZero,
  output logic [1:0]    dbg_state_o
);

  localparam int NSTEP = OPW / STEP_BITS;
  localparam int CW    = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_INJ} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     pair_q, pair_d;
  logic [OPW-1:0] dvd_q, dvd_d;
  logic [OPW-1:0] rem_q, rem_d;
  logic [OPW-1:0] dsr_q, dsr_d;
  logic [OPW-1:0] qres_q, qres_d;
  logic [OPW-1:0] nres_q, nres_d;
  logic           dzero_q, dzero_d;
  logic           dbz_q, dbz_d;

  logic [OPW-1:0] step_dvd, step_rem;
  logic [OPW:0]   trial;

  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom.
  always_comb begin
    step_dvd = dvd_q;
    step_rem = rem_q;
    trial    = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      trial    = {step_rem, step_dvd[OPW-1]};
      step_dvd = {step_dvd[OPW-2:0], 1'b0};
      if (trial >= {1'b0, dsr_q}) begin
        trial       = trial - {1'b0, dsr_q};
        step_dvd[0] = 1'b1;
      end
      step_rem = trial[OPW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pair_d  = pair_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    qres_d  = qres_q;
    nres_d  = nres_q;
    dzero_d = dzero_q;
    dbz_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (StartDiv102 && !RstCtrlJmp103) begin
          if (Divisor == '0) begin
            dbz_d = 1'b1;
          end else begin
            state_d = S_DIV;
            cnt_d   = '0;
            dvd_d   = Divident[OPW-1:0];
            rem_d   = '0;
            dsr_d   = Divisor[OPW-1:0];
            dzero_d = (Divident == '0);
          end
        end
      end
      S_DIV: begin
        if (RstCtrlJmp103) begin
          state_d = S_IDLE;
        end else begin
          dvd_d = step_dvd;
          rem_d = step_rem;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NSTEP - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        // Do-while semantics: the loop body runs once more than floor division implies.
        if (RstCtrlJmp103) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INJ;
          pair_d  = 2'd0;
          if (dzero_q) begin
            qres_d = OPW'(1);
            nres_d = dsr_q;
          end else if (rem_q != '0) begin
            qres_d = dvd_q + OPW'(1);
            nres_d = dsr_q - rem_q;
          end else begin
            qres_d = dvd_q;
            nres_d = '0;
          end
        end
      end
      S_INJ: begin
        pair_d = pair_q + 2'd1;
        if (pair_q == 2'd3) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pair_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      qres_q  <= '0;
      nres_q  <= '0;
      dzero_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      qres_q  <= qres_d;
      nres_q  <= nres_d;
      dzero_q <= dzero_d;
      dbz_q   <= dbz_d;
    end
  end

  // nres_q holds -R, so pair2 loads it into A and the C-instruction negates it into D.
  always_comb begin
    SelAccInst101   = (state_q == S_INJ);
    AccStall        = (state_q != S_IDLE);
    DivByZero       = dbz_q;
    dbg_state_o     = state_q;
    Inst0FromAcc101 = '0;
    Inst1FromAcc101 = '0;
    if (state_q == S_INJ) begin
      case (pair_q)
        2'd0: begin
          Inst0FromAcc101 = {{(DW-OPW){1'b0}}, qres_q};
          Inst1FromAcc101 = DW'(16'hEC10);
        end
        2'd1: begin
          Inst0FromAcc101 = DW'(16'h0001);
          Inst1FromAcc101 = DW'(16'hE308);
        end
        2'd2: begin
          Inst0FromAcc101 = {{(DW-OPW){1'b0}}, nres_q};
          Inst1FromAcc101 = DW'(16'hECD0);
        end
        default: begin
          Inst0FromAcc101 = DW'(16'h0002);
          Inst1FromAcc101 = DW'(16'hE308);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_acc.sv
// Directed bench for div_acc: vector table of divisions plus hand sequences for
// divide-by-zero, flushes, ignored restarts and reset during injection.
module tb_div_acc;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        StartDiv102;
  logic [15:0] Divident;
  logic [15:0] Divisor;
  logic        RstCtrlJmp103;
  logic        SelAccInst101;
  logic [15:0] Inst0FromAcc101;
  logic [15:0] Inst1FromAcc101;
  logic        AccStall;
  logic        DivByZero;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;

  div_acc dut (
    .Clk             (Clk),
    .Reset_N         (Reset_N),
    .StartDiv102     (StartDiv102),
    .Divident        (Divident),
    .Divisor         (Divisor),
    .RstCtrlJmp103   (RstCtrlJmp103),
    .SelAccInst101   (SelAccInst101),
    .Inst0FromAcc101 (Inst0FromAcc101),
    .Inst1FromAcc101 (Inst1FromAcc101),
    .AccStall        (AccStall),
    .DivByZero       (DivByZero),
    .dbg_state_o     (dbg_state_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] dvd;
    logic [15:0] dsr;
    logic [15:0] exp_q;
    logic [15:0] exp_nr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // mode 0: plain; 1: second Start mid-DIV (ignored); 2: flush during pair1 (ignored)
  task automatic run_op(input vec_t v, input int mode, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int lat;
    int extra;
    exp_q.push_back({v.exp_q, 16'hEC10});
    exp_q.push_back({16'h0001, 16'hE308});
    exp_q.push_back({v.exp_nr, 16'hECD0});
    exp_q.push_back({16'h0002, 16'hE308});
    Divident    = v.dvd;
    Divisor     = v.dsr;
    StartDiv102 = 1'b1;
    tick();
    StartDiv102 = 1'b0;
    chk({tag, " stall_first"}, 32'(AccStall), 32'd1);
    lat = 1;
    while (!SelAccInst101 && lat < 64) begin
      if (mode == 1 && lat == 3) begin
        Divident    = 16'd100;
        Divisor     = 16'd7;
        StartDiv102 = 1'b1;
      end
      tick();
      StartDiv102 = 1'b0;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd17);
    for (int p = 0; p < 4; p++) begin
      e = exp_q.pop_front();
      chk({tag, " sel"}, 32'(SelAccInst101), 32'd1);
      chk({tag, " pair"}, {Inst0FromAcc101, Inst1FromAcc101}, e);
      chk({tag, " stall_inj"}, 32'(AccStall), 32'd1);
      if (mode == 2 && p == 1) RstCtrlJmp103 = 1'b1;
      tick();
      RstCtrlJmp103 = 1'b0;
    end
    chk({tag, " sel_after"}, 32'(SelAccInst101), 32'd0);
    chk({tag, " stall_after"}, 32'(AccStall), 32'd0);
    chk({tag, " state_after"}, 32'(dbg_state_o), 32'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (SelAccInst101 || AccStall) extra++;
      tick();
    end
    chk({tag, " no_extra"}, 32'(extra), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'd20000, 16'd10,    16'd2000,  16'd0};
    vecs[1] = '{16'd7,     16'd2,     16'd4,     16'd1};
    vecs[2] = '{16'd0,     16'd5,     16'd1,     16'd5};
    vecs[3] = '{16'd32767, 16'd1,     16'd32767, 16'd0};
    vecs[4] = '{16'd100,   16'd7,     16'd15,    16'd5};
    vecs[5] = '{16'd1,     16'd32767, 16'd1,     16'd32766};
    vecs[6] = '{16'd32767, 16'd32767, 16'd1,     16'd0};
    vecs[7] = '{16'd12345, 16'd123,   16'd101,   16'd78};

    Reset_N       = 1'b0;
    StartDiv102   = 1'b0;
    RstCtrlJmp103 = 1'b0;
    Divident      = '0;
    Divisor       = '0;
    #12;
    chk("rst sel", 32'(SelAccInst101), 32'd0);
    chk("rst inst", {Inst0FromAcc101, Inst1FromAcc101}, 32'd0);
    chk("rst stall", 32'(AccStall), 32'd0);
    chk("rst dbz", 32'(DivByZero), 32'd0);
    chk("rst state", 32'(dbg_state_o), 32'd0);
    Reset_N = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_op(vecs[i], 0, $sformatf("vec%0d", i));

    // Divide by zero: pulse only, no stall, no injection
    Divident    = 16'd9;
    Divisor     = 16'd0;
    StartDiv102 = 1'b1;
    tick();
    StartDiv102 = 1'b0;
    chk("dbz pulse", 32'(DivByZero), 32'd1);
    chk("dbz stall", 32'(AccStall), 32'd0);
    chk("dbz sel", 32'(SelAccInst101), 32'd0);
    tick();
    chk("dbz pulse_end", 32'(DivByZero), 32'd0);
    chk("dbz state", 32'(dbg_state_o), 32'd0);

    // Flush in DIV cycle 5
    Divident    = 16'd1000;
    Divisor     = 16'd3;
    StartDiv102 = 1'b1;
    tick();
    StartDiv102 = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    chk("flush_div pre_state", 32'(dbg_state_o), 32'd1);
    RstCtrlJmp103 = 1'b1;
    tick();
    RstCtrlJmp103 = 1'b0;
    chk("flush_div state", 32'(dbg_state_o), 32'd0);
    chk("flush_div stall", 32'(AccStall), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (SelAccInst101) seen++;
        tick();
      end
      chk("flush_div no_inj", 32'(seen), 32'd0);
    end

    // Flush in FIX cycle (T+16)
    Divident    = 16'd50;
    Divisor     = 16'd4;
    StartDiv102 = 1'b1;
    tick();
    StartDiv102 = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    chk("flush_fix pre_state", 32'(dbg_state_o), 32'd2);
    RstCtrlJmp103 = 1'b1;
    tick();
    RstCtrlJmp103 = 1'b0;
    chk("flush_fix state", 32'(dbg_state_o), 32'd0);
    chk("flush_fix sel", 32'(SelAccInst101), 32'd0);

    // Start and flush together in IDLE: start dropped
    Divident      = 16'd50;
    Divisor       = 16'd4;
    StartDiv102   = 1'b1;
    RstCtrlJmp103 = 1'b1;
    tick();
    StartDiv102   = 1'b0;
    RstCtrlJmp103 = 1'b0;
    chk("start_flush stall", 32'(AccStall), 32'd0);
    chk("start_flush state", 32'(dbg_state_o), 32'd0);
    tick();

    run_op(vecs[1], 1, "mid_start");
    run_op(vecs[4], 2, "flush_inj");

    // Asynchronous reset during pair1
    Divident    = 16'd7;
    Divisor     = 16'd2;
    StartDiv102 = 1'b1;
    tick();
    StartDiv102 = 1'b0;
    for (int i = 1; i < 18; i++) tick();
    chk("rst_inj pre_pair1", {Inst0FromAcc101, Inst1FromAcc101}, {16'h0001, 16'hE308});
    #2;
    Reset_N = 1'b0;
    #1;
    chk("rst_inj sel", 32'(SelAccInst101), 32'd0);
    chk("rst_inj inst", {Inst0FromAcc101, Inst1FromAcc101}, 32'd0);
    chk("rst_inj stall", 32'(AccStall), 32'd0);
    tick();
    Reset_N = 1'b1;
    tick();
    chk("rst_inj idle", 32'(dbg_state_o), 32'd0);
    chk("rst_inj sel_rel", 32'(SelAccInst101), 32'd0);
    run_op(vecs[7], 0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
